// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: register map, data width and reset values.
package pwm_bank_pkg;

  localparam int DATA_W = 8;

  localparam logic [4:0] ADDR_EN_LO     = 5'h00;
  localparam logic [4:0] ADDR_EN_HI     = 5'h01;
  localparam logic [4:0] ADDR_PRE       = 5'h02;
  localparam logic [4:0] ADDR_TOP       = 5'h03;
  localparam logic [4:0] ADDR_DUTY_BASE = 5'h10;

  localparam logic [DATA_W-1:0] TOP_RST   = 8'hFF;
  localparam logic [DATA_W-1:0] DUTY_FULL = 8'hFF;

  // Output level for one channel; full-scale duty is always high regardless of top.
  function automatic logic pwm_level(input logic [DATA_W-1:0] cnt,
                                     input logic [DATA_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_bank_ch.sv
// One PWM channel: active duty storage and the registered compare output.
// PWM_BANK_SHADOW_EN selects shadowed duty that only changes at counter wrap.
module pwm_bank_ch
  import pwm_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ch_en,
  input  logic [DATA_W-1:0] cnt,
  input  logic              wrap,
  input  logic              duty_we,
  input  logic [DATA_W-1:0] duty_wdata,
  output logic              pwm_out
);

  logic [DATA_W-1:0] duty_act;

`ifdef PWM_BANK_SHADOW_EN
  logic [DATA_W-1:0] duty_sh;

  // While stopped no period is in flight, so the active duty tracks the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
    end else begin
      if (duty_we) duty_sh <= duty_wdata;
      if (wrap || !en) duty_act <= duty_we ? duty_wdata : duty_sh;
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_act <= '0;
    else if (duty_we) duty_act <= duty_wdata;
  end
`endif

  // Stage 1: compare against the counter value registered in stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out <= 1'b0;
    else        pwm_out <= en && ch_en && pwm_level(cnt, duty_act);
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: register decode, shared prescaler and period counter.
// Optional feature macro: PWM_BANK_SHADOW_EN (wrap-synchronous duty updates).
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int PRE_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_done
);

  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] duty_we;
  logic [PRE_W-1:0]  prescale;
  logic [PRE_W-1:0]  pre_cnt;
  logic [DATA_W-1:0] top;
  logic [DATA_W-1:0] cnt;
  logic              tick;
  logic              wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      top      <= TOP_RST;
    end else if (wr_en) begin
      if (wr_addr == ADDR_PRE) prescale <= wr_data[PRE_W-1:0];
      if (wr_addr == ADDR_TOP) top      <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [4:0] EN_ADDR   = (i < 8) ? ADDR_EN_LO : ADDR_EN_HI;
    localparam logic [4:0] DUTY_ADDR = ADDR_DUTY_BASE + 5'(i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ch_en[i] <= 1'b0;
      else if (wr_en && (wr_addr == EN_ADDR)) ch_en[i] <= wr_data[i % 8];
    end

    assign duty_we[i] = wr_en && (wr_addr == DUTY_ADDR);

    pwm_bank_ch u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .ch_en      (ch_en[i]),
      .cnt        (cnt),
      .wrap       (wrap),
      .duty_we    (duty_we[i]),
      .duty_wdata (wr_data),
      .pwm_out    (pwm_out[i])
    );
  end

  // A prescale or top lowered below the running count still terminates the period.
  assign tick = en && (pre_cnt >= prescale);
  assign wrap = tick && (cnt >= top);

  // Stage 0: prescaler and period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      period_done <= 1'b0;
    end else if (!en) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      period_done <= 1'b0;
    end else begin
      period_done <= wrap;
      if (tick) begin
        pre_cnt <= '0;
        cnt     <= wrap ? '0 : cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed scoreboard bench for pwm_bank: per-clock expected outputs are queued
// with the stimulus and compared at each falling edge.
module tb_pwm_bank;
  import pwm_bank_pkg::*;

  localparam int NCH = 8;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b0;
  logic           en      = 1'b0;
  logic           wr_en   = 1'b0;
  logic [4:0]     wr_addr = '0;
  logic [7:0]     wr_data = '0;
  logic [NCH-1:0] pwm_out;
  logic           period_done;

  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic           done;
  } exp_t;

  exp_t  sb[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    k_idx      = 0;
  string tag        = "";

  pwm_bank #(.NUM_CH(NCH), .PRE_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      assert (pwm_out === e.pwm) else begin
        mismatched++;
        $error("FAIL %s.pwm k=%0d observed=%h expected=%h", tag, k_idx, pwm_out, e.pwm);
      end
      compared++;
      assert (period_done === e.done) else begin
        mismatched++;
        $error("FAIL %s.done k=%0d observed=%b expected=%b", tag, k_idx, period_done, e.done);
      end
      k_idx++;
    end
  endtask

  task automatic check_now(input string t);
    compared++;
    assert (pwm_out === '0) else begin
      mismatched++;
      $error("FAIL %s.pwm observed=%h expected=%h", t, pwm_out, {NCH{1'b0}});
    end
    compared++;
    assert (period_done === 1'b0) else begin
      mismatched++;
      $error("FAIL %s.done observed=%b expected=0", t, period_done);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Sample k after the first enabled edge: high while k mod per < hi, done on the last clk.
  task automatic push_periodic(input logic [NCH-1:0] mask, input int hi, input int per,
                               input int n, input string t);
    exp_t e;
    tag   = t;
    k_idx = 0;
    for (int k = 0; k < n; k++) begin
      e.pwm  = ((k % per) < hi) ? mask : '0;
      e.done = ((k % per) == per - 1);
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    wr_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    logic h;

    repeat (2) @(negedge clk);
    check_now("reset");
    rst_n = 1'b1;

    // Idle run with decoy writes to unmapped / nonexistent locations.
    wr(5'h0B, 8'h05);
    wr(5'h18, 8'h80);
    wr(ADDR_EN_HI, 8'hFF);
    push_periodic('0, 0, 256, 512, "idle");
    en = 1'b1;
    repeat (512) step();

    do_reset();
    wr(ADDR_TOP, 8'd9);
    wr(ADDR_EN_LO, 8'h01);
    wr(ADDR_DUTY_BASE, 8'd3);
    push_periodic(8'h01, 3, 10, 30, "top9_duty3");
    en = 1'b1;
    repeat (30) step();

    do_reset();
    wr(ADDR_PRE, 8'd1);
    wr(ADDR_TOP, 8'd3);
    wr(ADDR_DUTY_BASE + 5'd1, 8'd2);
    wr(ADDR_EN_LO, 8'h02);
    push_periodic(8'h02, 4, 8, 24, "pre1_top3");
    en = 1'b1;
    repeat (24) step();

    do_reset();
    wr(ADDR_TOP, 8'h10);
    wr(ADDR_EN_LO, 8'h04);
    wr(ADDR_DUTY_BASE + 5'd2, 8'h00);
    push_periodic(8'h04, 0, 17, 34, "duty00");
    en = 1'b1;
    repeat (34) step();
    en = 1'b0;
    wr(ADDR_DUTY_BASE + 5'd2, 8'hFF);
    push_periodic(8'h04, 17, 17, 34, "dutyFF");
    en = 1'b1;
    repeat (34) step();
    en = 1'b0;
    wr(ADDR_DUTY_BASE + 5'd2, 8'h20);
    push_periodic(8'h04, 17, 17, 34, "duty_gt_top");
    en = 1'b1;
    repeat (34) step();

    // Duty 3 -> 7 mid-period, then 7 -> 1 written on the wrap clock.
    do_reset();
    wr(ADDR_TOP, 8'd9);
    wr(ADDR_EN_LO, 8'h01);
    wr(ADDR_DUTY_BASE, 8'd3);
    tag   = "duty_change";
    k_idx = 0;
    for (int k = 0; k < 30; k++) begin
      if (k < 10)      h = (k < 3);
      else if (k < 20) h = ((k - 10) < 7);
      else             h = (k == 20);
`ifndef PWM_BANK_SHADOW_EN
      if (k == 5 || k == 6) h = 1'b1;
`endif
      e.pwm  = h ? 8'h01 : 8'h00;
      e.done = ((k % 10) == 9);
      sb.push_back(e);
    end
    en = 1'b1;
    repeat (4) step();
    wr(ADDR_DUTY_BASE, 8'd7);
    repeat (14) step();
    wr(ADDR_DUTY_BASE, 8'd1);
    repeat (10) step();

    // Asynchronous reset while the output is high, then a default-top period.
    do_reset();
    wr(ADDR_TOP, 8'd9);
    wr(ADDR_EN_LO, 8'h01);
    wr(ADDR_DUTY_BASE, 8'd3);
    push_periodic(8'h01, 3, 10, 2, "pre_async");
    en = 1'b1;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1 check_now("async_rst");
    @(negedge clk);
    push_periodic('0, 0, 256, 256, "post_rst");
    rst_n = 1'b1;
    repeat (256) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
